ex_stage: RTL and testbench

Execute stage of the 5-stage SimpleRISC pipeline, directly downstream of operand fetch. It consumes the fetched operands, PC, IR, branch target and 22-bit control bus. It computes the ALU result, maintains the E/GT flags register and resolves branches. Results are registered into the EX/MA latch for the memory-access stage. Signed DIV/MOD run on an iterative divider that stalls operand fetch while busy.

---
 rtl/ex_pkg.sv | 28 ++
 rtl/iterative_divider.sv | 67 ++++++
 rtl/ex_stage.sv | 139 +++++++++++++
 tb/tb_ex_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the SimpleRISC execute stage: control-bus bit
// positions and the execute FSM state encoding.
package ex_pkg;
   localparam int B_ST   = 0;
   localparam int B_LD   = 1;
   localparam int B_BEQ  = 2;
   localparam int B_BGT  = 3;
   localparam int B_RET  = 4;
   localparam int B_IMM  = 5;
   localparam int B_WB   = 6;
   localparam int B_UBR  = 7;
   localparam int B_CALL = 8;
   localparam int B_ADD  = 9;
   localparam int B_SUB  = 10;
   localparam int B_CMP  = 11;
   localparam int B_MUL  = 12;
   localparam int B_DIV  = 13;
   localparam int B_MOD  = 14;
   localparam int B_LSL  = 15;
   localparam int B_LSR  = 16;
   localparam int B_ASR  = 17;
   localparam int B_OR   = 18;
   localparam int B_AND  = 19;
   localparam int B_NOT  = 20;
   localparam int B_MOV  = 21;

   typedef enum logic [1:0] {IDLE, DIV, FIX} ex_state_e;
endpackage

// File: rtl/iterative_divider.sv
// Signed restoring divider: 32 magnitude iterations, then one FIX cycle that
// applies sign correction and the divide-by-zero rule.
module iterative_divider #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_start,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_busy,
   output logic         o_last,
   output logic         o_done,
   output logic [W-1:0] o_quot,
   output logic [W-1:0] o_rem
);
   logic         r_busy, r_fix, r_a_neg, r_b_neg, r_bz;
   logic [5:0]   r_cnt;
   logic [W-1:0] r_q, r_r, r_dvs, r_a;
   logic [W-1:0] w_shift;
   logic [W:0]   w_diff;

   // r_q doubles as the dividend shift register; its MSB feeds the remainder
   assign w_shift = {r_r[W-2:0], r_q[W-1]};
   assign w_diff  = {1'b0, w_shift} - {1'b0, r_dvs};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy  <= 1'b0;
         r_fix   <= 1'b0;
         r_cnt   <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_dvs   <= '0;
         r_a     <= '0;
         r_a_neg <= 1'b0;
         r_b_neg <= 1'b0;
         r_bz    <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_busy  <= 1'b1;
         r_fix   <= 1'b0;
         r_cnt   <= '0;
         r_q     <= i_a[W-1] ? -i_a : i_a;
         r_r     <= '0;
         r_dvs   <= i_b[W-1] ? -i_b : i_b;
         r_a     <= i_a;
         r_a_neg <= i_a[W-1];
         r_b_neg <= i_b[W-1];
         r_bz    <= (i_b == '0);
      end else if (r_busy && !r_fix) begin
         r_q <= {r_q[W-2:0], ~w_diff[W]};
         r_r <= w_diff[W] ? w_shift : w_diff[W-1:0];
         if (r_cnt == 6'(W-1)) r_fix <= 1'b1;
         else                  r_cnt <= r_cnt + 6'd1;
      end else if (r_fix) begin
         r_fix  <= 1'b0;
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end
   end

   assign o_busy = r_busy;
   assign o_last = r_busy && !r_fix && (r_cnt == 6'(W-1));
   assign o_done = r_fix;
   assign o_quot = r_bz ? '1  : ((r_a_neg ^ r_b_neg) ? -r_q : r_q);
   assign o_rem  = r_bz ? r_a : (r_a_neg ? -r_r : r_r);
endmodule

// File: rtl/ex_stage.sv
// SimpleRISC execute stage: ALU, E/GT flags, branch resolution and the EX/MA
// latch; DIV/MOD are handed to the iterative divider while in_ready is low.
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 22
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_ir,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [XLEN-1:0]   in_branch_target,
   input  logic [XLEN-1:0]   in_op_a,
   input  logic [XLEN-1:0]   in_op_b,
   input  logic [XLEN-1:0]   in_op_2,
   output logic              out_valid,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_ir,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [XLEN-1:0]   out_alu_result,
   output logic [XLEN-1:0]   out_op_2,
   output logic              branch_taken,
   output logic [XLEN-1:0]   branch_pc,
   output logic              flag_e,
   output logic              flag_gt
);
   ex_state_e         r_state, w_state_nxt;
   logic              w_accept, w_is_div, w_taken, w_div_start;
   logic              w_div_busy, w_div_last, w_div_done;
   logic [XLEN-1:0]   w_alu, w_div_q, w_div_r;
   logic [XLEN-1:0]   r_s_pc, r_s_ir, r_s_op_2;
   logic [CTRL_W-1:0] r_s_ctrl;
   logic              r_valid, r_taken, r_e, r_gt;
   logic [XLEN-1:0]   r_pc, r_ir, r_res, r_op_2, r_bpc;
   logic [CTRL_W-1:0] r_ctrl;

   assign w_is_div    = in_ctrl[B_DIV] | in_ctrl[B_MOD];
   assign w_accept    = in_valid && (r_state == IDLE);
   assign w_div_start = w_accept && w_is_div && !w_div_busy;
   // Flags are read before this instruction's own cmp update lands
   assign w_taken     = in_ctrl[B_UBR] | (in_ctrl[B_BEQ] & r_e) | (in_ctrl[B_BGT] & r_gt);

   always_comb begin
      w_alu = '0;
      if (in_ctrl[B_ADD]) w_alu = in_op_a + in_op_b;
      if (in_ctrl[B_SUB]) w_alu = in_op_a - in_op_b;
      if (in_ctrl[B_CMP]) w_alu = in_op_a - in_op_b;
      if (in_ctrl[B_MUL]) w_alu = $unsigned($signed(in_op_a) * $signed(in_op_b));
      if (in_ctrl[B_LSL]) w_alu = in_op_a << in_op_b[4:0];
      if (in_ctrl[B_LSR]) w_alu = in_op_a >> in_op_b[4:0];
      if (in_ctrl[B_ASR]) w_alu = $unsigned($signed(in_op_a) >>> in_op_b[4:0]);
      if (in_ctrl[B_OR])  w_alu = in_op_a | in_op_b;
      if (in_ctrl[B_AND]) w_alu = in_op_a & in_op_b;
      if (in_ctrl[B_NOT]) w_alu = ~in_op_b;
      if (in_ctrl[B_MOV]) w_alu = in_op_b;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_div_start) w_state_nxt = DIV;
         DIV:     if (w_div_last)  w_state_nxt = FIX;
         FIX:     if (w_div_done)  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   iterative_divider #(.W(XLEN)) u_div (
      .clk     (clk),
      .reset_n (reset_n),
      .i_start (w_div_start),
      .i_a     (in_op_a),
      .i_b     (in_op_b),
      .o_busy  (w_div_busy),
      .o_last  (w_div_last),
      .o_done  (w_div_done),
      .o_quot  (w_div_q),
      .o_rem   (w_div_r)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {r_s_pc, r_s_ir, r_s_op_2, r_s_ctrl} <= '0;
         {r_valid, r_taken, r_e, r_gt}        <= '0;
         {r_pc, r_ir, r_res, r_op_2, r_bpc}   <= '0;
         r_ctrl                               <= '0;
      end else begin
         r_valid <= 1'b0;
         r_taken <= 1'b0;
         if (w_div_start) begin
            r_s_pc   <= in_pc;
            r_s_ir   <= in_ir;
            r_s_ctrl <= in_ctrl;
            r_s_op_2 <= in_op_2;
         end else if (w_accept) begin
            r_valid <= 1'b1;
            r_taken <= w_taken;
            r_pc    <= in_pc;
            r_ir    <= in_ir;
            r_ctrl  <= in_ctrl;
            r_op_2  <= in_op_2;
            r_bpc   <= in_ctrl[B_RET] ? in_op_a : in_branch_target;
            r_res   <= in_ctrl[B_CALL] ? in_pc + 32'd4 : w_alu;
            if (in_ctrl[B_CMP]) begin
               r_e  <= (in_op_a == in_op_b);
               r_gt <= ($signed(in_op_a) > $signed(in_op_b));
            end
         end else if (r_state == FIX && w_div_done) begin
            r_valid <= 1'b1;
            r_pc    <= r_s_pc;
            r_ir    <= r_s_ir;
            r_ctrl  <= r_s_ctrl;
            r_op_2  <= r_s_op_2;
            r_res   <= r_s_ctrl[B_MOD] ? w_div_r : w_div_q;
         end
      end
   end

   assign in_ready       = reset_n && (r_state == IDLE);
   assign out_valid      = r_valid;
   assign out_pc         = r_pc;
   assign out_ir         = r_ir;
   assign out_ctrl       = r_ctrl;
   assign out_alu_result = r_res;
   assign out_op_2       = r_op_2;
   assign branch_taken   = r_taken;
   assign branch_pc      = r_bpc;
   assign flag_e         = r_e;
   assign flag_gt        = r_gt;
endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: ALU ops, flags, branches, divider
// latency and corner cases, and reset while a divide is in flight.
module tb_ex_stage;
   import ex_pkg::*;

   logic        clk, reset_n, in_valid, in_ready;
   logic [31:0] in_pc, in_ir, in_branch_target, in_op_a, in_op_b, in_op_2;
   logic [21:0] in_ctrl, out_ctrl;
   logic        out_valid, branch_taken, flag_e, flag_gt;
   logic [31:0] out_pc, out_ir, out_alu_result, out_op_2, branch_pc;
   int          n_cmp = 0, n_err = 0;
   logic [31:0] res;
   int          cyc, pulses;
   logic        rdy_seen;

   ex_stage dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_ir(in_ir), .in_ctrl(in_ctrl),
      .in_branch_target(in_branch_target), .in_op_a(in_op_a), .in_op_b(in_op_b),
      .in_op_2(in_op_2), .out_valid(out_valid), .out_pc(out_pc), .out_ir(out_ir),
      .out_ctrl(out_ctrl), .out_alu_result(out_alu_result), .out_op_2(out_op_2),
      .branch_taken(branch_taken), .branch_pc(branch_pc),
      .flag_e(flag_e), .flag_gt(flag_gt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [21:0] cb(input int i);
      logic [21:0] one;
      one = 22'd1;
      return one << i;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [21:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] tgt);
      in_ctrl = c; in_op_a = a; in_op_b = b; in_pc = pc; in_branch_target = tgt;
      in_ir = pc ^ 32'hA5A5_0000; in_op_2 = ~a; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic run_div(input logic [21:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int n, output logic rdy);
      issue(c, a, b, 32'h500, 32'h0);
      // upstream keeps presenting an unrelated op that must be ignored
      in_ctrl = cb(B_ADD); in_op_a = 32'h11; in_op_b = 32'h22; in_pc = 32'h600; in_valid = 1'b1;
      n = 0; rdy = 1'b0;
      while (out_valid !== 1'b1 && n < 100) begin
         if (in_ready) rdy = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      r = out_alu_result;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_pc = '0; in_ir = '0;
      in_branch_target = '0; in_op_a = '0; in_op_b = '0; in_op_2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_result", out_alu_result, 32'd0);
      chk("rst_flags", {30'd0, flag_e, flag_gt}, 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      @(negedge clk); reset_n = 1'b1;
      #1 chk("ready_after_rst", 32'(in_ready), 32'd1);
      @(negedge clk);

      issue(cb(B_ADD), 32'h7FFF_FFFF, 32'd1, 32'h10, 32'h0);
      chk("add_ovf", out_alu_result, 32'h8000_0000);
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_pc", out_pc, 32'h10);
      chk("add_op2", out_op_2, 32'h8000_0000);
      chk("add_flags", {30'd0, flag_e, flag_gt}, 32'd0);
      @(posedge clk); #1;
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("result_hold", out_alu_result, 32'h8000_0000);

      issue(cb(B_CMP), 32'd5, 32'd5, 32'h14, 32'h0);
      chk("cmp_eq_flags", {30'd0, flag_e, flag_gt}, 32'b10);
      issue(cb(B_BEQ), 32'd0, 32'd0, 32'h18, 32'h100);
      chk("beq_valid", 32'(out_valid), 32'd1);
      chk("beq_taken", 32'(branch_taken), 32'd1);
      chk("beq_pc", branch_pc, 32'h100);
      issue(cb(B_BGT), 32'd0, 32'd0, 32'h1C, 32'h200);
      chk("bgt_not_taken", 32'(branch_taken), 32'd0);
      issue(cb(B_CMP), 32'd7, 32'hFFFF_FFFD, 32'h20, 32'h0);
      chk("cmp_gt_flags", {30'd0, flag_e, flag_gt}, 32'b01);
      issue(cb(B_BGT), 32'd0, 32'd0, 32'h24, 32'h300);
      chk("bgt_taken", 32'(branch_taken), 32'd1);
      chk("bgt_pc", branch_pc, 32'h300);
      issue(cb(B_BEQ), 32'd0, 32'd0, 32'h28, 32'h400);
      chk("beq_not_taken", 32'(branch_taken), 32'd0);

      issue(cb(B_RET) | cb(B_UBR), 32'h40, 32'd0, 32'h2C, 32'h999);
      chk("ret_taken", 32'(branch_taken), 32'd1);
      chk("ret_pc", branch_pc, 32'h40);
      issue(cb(B_CALL) | cb(B_UBR), 32'd0, 32'd0, 32'h20, 32'h200);
      chk("call_result", out_alu_result, 32'h24);
      chk("call_pc", branch_pc, 32'h200);

      issue(cb(B_SUB), 32'd0, 32'd1, 32'h30, 32'h0);
      chk("sub_wrap", out_alu_result, 32'hFFFF_FFFF);
      issue(cb(B_MUL), 32'hFFFF_FFFD, 32'd5, 32'h34, 32'h0);
      chk("mul_neg", out_alu_result, 32'hFFFF_FFF1);
      issue(cb(B_LSL), 32'd1, 32'h21, 32'h38, 32'h0);
      chk("lsl_amt5", out_alu_result, 32'd2);
      issue(cb(B_LSR), 32'h8000_0000, 32'd4, 32'h3C, 32'h0);
      chk("lsr", out_alu_result, 32'h0800_0000);
      issue(cb(B_ASR), 32'h8000_0000, 32'd4, 32'h40, 32'h0);
      chk("asr", out_alu_result, 32'hF800_0000);
      issue(cb(B_AND), 32'hF0F0_1234, 32'h0FF0_FF00, 32'h44, 32'h0);
      chk("and", out_alu_result, 32'h00F0_1200);
      issue(cb(B_OR), 32'hF000_0001, 32'h0000_00F0, 32'h48, 32'h0);
      chk("or", out_alu_result, 32'hF000_00F1);
      issue(cb(B_NOT), 32'h1234, 32'h0, 32'h4C, 32'h0);
      chk("not", out_alu_result, 32'hFFFF_FFFF);
      issue(cb(B_MOV), 32'h1234, 32'hCAFE, 32'h50, 32'h0);
      chk("mov", out_alu_result, 32'hCAFE);
      issue(cb(B_WB), 32'h1234, 32'hCAFE, 32'h54, 32'h0);
      chk("no_alu_op", out_alu_result, 32'd0);
      chk("flags_kept", {30'd0, flag_e, flag_gt}, 32'b01);

      run_div(cb(B_DIV), 32'hFFFF_FFF9, 32'd2, res, cyc, rdy_seen);
      chk("div_latency", 32'(cyc), 32'd33);
      chk("div_ready_low", 32'(rdy_seen), 32'd0);
      chk("div_neg", res, 32'hFFFF_FFFD);
      chk("div_pc_snap", out_pc, 32'h500);
      chk("div_ready_back", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk("div_valid_drop", 32'(out_valid), 32'd0);
      run_div(cb(B_MOD), 32'hFFFF_FFF9, 32'd2, res, cyc, rdy_seen);
      chk("mod_neg", res, 32'hFFFF_FFFF);
      run_div(cb(B_DIV), 32'd100, 32'd7, res, cyc, rdy_seen);
      chk("div_pos", res, 32'd14);
      run_div(cb(B_MOD), 32'hFFFF_FF9C, 32'd7, res, cyc, rdy_seen);
      chk("mod_sign", res, 32'hFFFF_FFFE);
      run_div(cb(B_DIV), 32'd9, 32'd0, res, cyc, rdy_seen);
      chk("div_by0", res, 32'hFFFF_FFFF);
      run_div(cb(B_MOD), 32'd9, 32'd0, res, cyc, rdy_seen);
      chk("mod_by0", res, 32'd9);
      run_div(cb(B_DIV), 32'h8000_0000, 32'hFFFF_FFFF, res, cyc, rdy_seen);
      chk("div_ovf", res, 32'h8000_0000);
      run_div(cb(B_MOD), 32'h8000_0000, 32'hFFFF_FFFF, res, cyc, rdy_seen);
      chk("mod_ovf", res, 32'd0);
      chk("div_flags_kept", {30'd0, flag_e, flag_gt}, 32'b01);

      // reset lands mid-divide
      run_div(cb(B_DIV), 32'd100, 32'd7, res, cyc, rdy_seen);
      issue(cb(B_DIV), 32'd50, 32'd5, 32'h700, 32'h0);
      repeat (10) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_div_result", out_alu_result, 32'd0);
      chk("rst_div_pc", out_pc, 32'd0);
      chk("rst_div_flags", {30'd0, flag_e, flag_gt}, 32'd0);
      chk("rst_div_valid", 32'(out_valid), 32'd0);
      @(negedge clk); @(negedge clk); reset_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) pulses++;
      end
      chk("rst_div_no_pulse", 32'(pulses), 32'd0);
      issue(cb(B_ADD), 32'd1, 32'd1, 32'h80, 32'h0);
      chk("add_after_rst", out_alu_result, 32'd2);
      chk("add_after_rst_v", 32'(out_valid), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
